// File: rtl/pd_player_multi.sv
// pd_player_multi: iterated Prisoner's Dilemma player with run-time selectable strategy.
// Defining PD_NOISE_EN adds an LFSR-driven trembling hand (1/16 move flips) and the noise_flip port.
module pd_player_multi #(
    parameter int HIST_DEPTH  = 8,
    parameter int CNT_W       = 16,
    parameter int ROUNDS      = 200,
    parameter int ENDGAME     = 2,
    parameter int FORGIVE_PCT = 70
`ifdef PD_NOISE_EN
    ,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             round_valid,
    input  logic             action_opp,
    output logic             action_self,
    output logic [CNT_W-1:0] round_count,
    output logic [CNT_W-1:0] opp_coop_count,
    output logic             done
`ifdef PD_NOISE_EN
    ,
    output logic             noise_flip
`endif
);

    localparam int FILL_W = $clog2(HIST_DEPTH + 1);
    localparam int PROD_W = CNT_W + 7;
    localparam logic [CNT_W-1:0]  ROUNDS_C      = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0]  ENDGAME_START = CNT_W'(ROUNDS - ENDGAME);
    localparam logic [FILL_W-1:0] FILL_MAX      = FILL_W'(HIST_DEPTH);
    localparam logic [PROD_W-1:0] PCT_C         = PROD_W'(FORGIVE_PCT);
    localparam logic [PROD_W-1:0] HUNDRED_C     = PROD_W'(100);

    typedef enum logic [1:0] {
        MODE_TFT    = 2'd0,
        MODE_TF2T   = 2'd1,
        MODE_GRIM   = 2'd2,
        MODE_WINDOW = 2'd3
    } mode_e;

    mode_e                 r_mode;
    logic [HIST_DEPTH-1:0] r_hist;
    logic [FILL_W-1:0]     r_fill;
    logic                  r_grim;

    logic                  w_accept;
    logic [HIST_DEPTH-1:0] w_hist_nxt;
    logic [FILL_W-1:0]     w_fill_nxt;
    logic [CNT_W-1:0]      w_round_nxt;
    logic                  w_grim_nxt;
    logic [FILL_W-1:0]     w_coop_cnt;
    logic [PROD_W-1:0]     w_coop_scaled;
    logic [PROD_W-1:0]     w_fill_scaled;
    logic                  w_move_strat;
    logic                  w_endgame;
    logic                  w_move;

    assign w_accept    = round_valid & ~done;
    assign w_hist_nxt  = {r_hist[HIST_DEPTH-2:0], action_opp};
    assign w_fill_nxt  = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
    assign w_round_nxt = round_count + CNT_W'(1);
    assign w_grim_nxt  = r_grim | action_opp;
    assign w_endgame   = (ENDGAME != 0) && (w_round_nxt >= ENDGAME_START);

    // Only the newest fill entries are valid history; older slots are still the reset value.
    always_comb begin
        w_coop_cnt = '0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if ((FILL_W'(i) < w_fill_nxt) && !w_hist_nxt[i]) begin
                w_coop_cnt = w_coop_cnt + FILL_W'(1);
            end
        end
    end

    assign w_coop_scaled = PROD_W'(w_coop_cnt) * HUNDRED_C;
    assign w_fill_scaled = PCT_C * PROD_W'(w_fill_nxt);

    always_comb begin
        w_move_strat = action_opp;
        case (r_mode)
            MODE_TFT:    w_move_strat = action_opp;
            MODE_TF2T:   w_move_strat = (w_fill_nxt == FILL_W'(1)) ? action_opp
                                                                  : (w_hist_nxt[0] & w_hist_nxt[1]);
            MODE_GRIM:   w_move_strat = w_grim_nxt;
            MODE_WINDOW: w_move_strat = (w_coop_scaled < w_fill_scaled);
            default:     w_move_strat = action_opp;
        endcase
    end

`ifdef PD_NOISE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;
    logic        w_flip;

    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_flip     = (w_lfsr_nxt[3:0] == 4'h0);
    // Endgame override sits after the flip so the final rounds always defect.
    assign w_move     = w_endgame | (w_move_strat ^ w_flip);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr     <= LFSR_SEED;
            noise_flip <= 1'b0;
        end else if (w_accept) begin
            r_lfsr     <= w_lfsr_nxt;
            noise_flip <= w_flip;
        end
    end
`else
    assign w_move = w_endgame | w_move_strat;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode         <= mode_e'(mode);
            r_hist         <= '0;
            r_fill         <= '0;
            r_grim         <= 1'b0;
            action_self    <= 1'b0;
            round_count    <= '0;
            opp_coop_count <= '0;
            done           <= 1'b0;
        end else if (w_accept) begin
            r_hist      <= w_hist_nxt;
            r_fill      <= w_fill_nxt;
            r_grim      <= w_grim_nxt;
            action_self <= w_move;
            round_count <= w_round_nxt;
            if (!action_opp && (opp_coop_count != {CNT_W{1'b1}})) begin
                opp_coop_count <= opp_coop_count + CNT_W'(1);
            end
            if (w_round_nxt == ROUNDS_C) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pd_player_multi.sv
// Self-checking bench for pd_player_multi: table vectors, long-game corners and randomized games
// checked against a round-by-round behavioural model of the player.
module tb_pd_player_multi;

    localparam int HD = 8;
    localparam int CW = 16;
    localparam int RN = 200;
    localparam int EG = 2;
    localparam int FP = 70;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic          round_valid;
    logic          action_opp;
    logic          action_self;
    logic [CW-1:0] round_count;
    logic [CW-1:0] opp_coop_count;
    logic          done;
`ifdef PD_NOISE_EN
    logic          noise_flip;
`endif

    pd_player_multi #(
        .HIST_DEPTH (HD),
        .CNT_W      (CW),
        .ROUNDS     (RN),
        .ENDGAME    (EG),
        .FORGIVE_PCT(FP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mode          (mode),
        .round_valid   (round_valid),
        .action_opp    (action_opp),
        .action_self   (action_self),
        .round_count   (round_count),
        .opp_coop_count(opp_coop_count),
        .done          (done)
`ifdef PD_NOISE_EN
        ,
        .noise_flip    (noise_flip)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: the full game state in plain terms.
    int          m_mode;
    int          m_n;
    int          m_coop;
    bit          m_grim;
    bit          m_act;
    bit          m_done;
    bit          m_flip;
    bit          m_hist[$];
    logic [15:0] m_lfsr;

    task automatic m_reset(input int md);
        m_mode = md;
        m_n    = 0;
        m_coop = 0;
        m_grim = 0;
        m_act  = 0;
        m_done = 0;
        m_flip = 0;
        m_hist.delete();
        m_lfsr = 16'hACE1;
    endtask

    task automatic m_round(input bit opp);
        int c;
        if (m_done) return;
        m_n++;
        m_hist.push_back(opp);
        if (m_hist.size() > HD) void'(m_hist.pop_front());
        if (!opp && m_coop < 65535) m_coop++;
        if (opp) m_grim = 1;
        case (m_mode)
            0: m_act = opp;
            1: m_act = (m_hist.size() < 2) ? opp : (opp && m_hist[m_hist.size()-2]);
            2: m_act = m_grim;
            default: begin
                c = 0;
                foreach (m_hist[i]) if (!m_hist[i]) c++;
                m_act = !(c * 100 >= FP * m_hist.size());
            end
        endcase
`ifdef PD_NOISE_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        m_flip = (m_lfsr[3:0] == 4'h0);
        if (m_flip) m_act = !m_act;
`endif
        if (EG > 0 && m_n >= RN - EG) m_act = 1;
        if (m_n == RN) m_done = 1;
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (round %0d)", name, act, exp, m_n);
        end
    endtask

    task automatic check_all(input string tag);
        check1({tag, " action_self"}, 32'(action_self), 32'(m_act));
        check1({tag, " round_count"}, 32'(round_count), 32'(m_n));
        check1({tag, " opp_coop_count"}, 32'(opp_coop_count), 32'(m_coop));
        check1({tag, " done"}, 32'(done), 32'(m_done));
`ifdef PD_NOISE_EN
        check1({tag, " noise_flip"}, 32'(noise_flip), 32'(m_flip));
`endif
    endtask

    task automatic do_reset(input int md);
        @(negedge clk);
        reset       = 1'b1;
        mode        = 2'(md);
        round_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        mode  = 2'($urandom_range(0, 3));
        m_reset(md);
    endtask

    task automatic do_round(input bit opp, input bit rv);
        @(negedge clk);
        round_valid = rv;
        action_opp  = opp;
        @(posedge clk);
        #1;
        round_valid = 1'b0;
        if (rv) m_round(opp);
    endtask

    typedef struct {
        int        md;
        int        len;
        bit [15:0] opp;
        bit [15:0] exp;
    } vec_t;

    vec_t vecs[4];
    bit   flips_a[60];

    initial begin
        reset       = 1'b0;
        mode        = 2'd0;
        round_valid = 1'b0;
        action_opp  = 1'b0;

        // bit i of opp/exp is round i+1
        vecs[0] = '{0, 4, 16'h0006, 16'h0006};
        vecs[1] = '{1, 5, 16'h000D, 16'h0009};
        vecs[2] = '{2, 5, 16'h0004, 16'h001C};
        vecs[3] = '{3, 9, 16'h0118, 16'h0130};

        do_reset(0);
        check1("reset action_self", 32'(action_self), 32'd0);
        check1("reset round_count", 32'(round_count), 32'd0);
        check1("reset opp_coop_count", 32'(opp_coop_count), 32'd0);
        check1("reset done", 32'(done), 32'd0);

        foreach (vecs[v]) begin
            do_reset(vecs[v].md);
            for (int r = 0; r < vecs[v].len; r++) begin
                do_round(vecs[v].opp[r], 1'b1);
                check1($sformatf("vec%0d r%0d move", v, r + 1), 32'(action_self),
                       32'(vecs[v].exp[r] ^ m_flip));
                check_all($sformatf("vec%0d r%0d", v, r + 1));
            end
        end
        check1("vec3 hold round_count", 32'(round_count), 32'd9);
        do_round(1'b1, 1'b0);
        check_all("idle hold");

        // Full TFT game against an always-cooperating opponent.
        do_reset(0);
        for (int r = 1; r <= RN; r++) begin
            do_round(1'b0, 1'b1);
            check_all($sformatf("full r%0d", r));
            if (r >= RN - EG) check1($sformatf("endgame r%0d", r), 32'(action_self), 32'd1);
        end
        check1("full done", 32'(done), 32'd1);
        check1("full coop", 32'(opp_coop_count), 32'(RN));
        do_round(1'b0, 1'b1);
        check1("after done round_count", 32'(round_count), 32'(RN));
        check_all("after done");

        // Reset wins over a simultaneous round strobe; mode latched only in reset.
        do_reset(0);
        for (int r = 0; r < 49; r++) do_round(1'($urandom_range(0, 1)), 1'b1);
        @(negedge clk);
        reset       = 1'b1;
        round_valid = 1'b1;
        action_opp  = 1'b1;
        mode        = 2'd2;
        @(posedge clk);
        #1;
        reset       = 1'b0;
        round_valid = 1'b0;
        mode        = 2'd0;
        m_reset(2);
        check1("midreset round_count", 32'(round_count), 32'd0);
        check1("midreset action_self", 32'(action_self), 32'd0);
        check1("midreset done", 32'(done), 32'd0);
        do_round(1'b0, 1'b1);
        check_all("latch r1");
        do_round(1'b1, 1'b1);
        check_all("latch r2");
        do_round(1'b0, 1'b1);
        check_all("latch r3");
        do_round(1'b0, 1'b1);
        check_all("latch r4");

        // Randomized games with idle gaps.
        for (int g = 0; g < 6; g++) begin
            do_reset($urandom_range(0, 3));
            for (int r = 0; r < 215; r++) begin
                do_round(1'($urandom_range(0, 99) < 35), 1'($urandom_range(0, 3) != 0));
                check_all($sformatf("rand g%0d m%0d", g, m_mode));
            end
        end

`ifdef PD_NOISE_EN
        do_reset(1);
        for (int r = 0; r < 60; r++) begin
            do_round(1'(r % 3 == 0), 1'b1);
            flips_a[r] = noise_flip;
            check_all("noise first");
        end
        do_reset(1);
        for (int r = 0; r < 60; r++) begin
            do_round(1'(r % 3 == 0), 1'b1);
            check1($sformatf("noise replay r%0d", r + 1), 32'(noise_flip), 32'(flips_a[r]));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
